// File: rtl/sonic_pkg.sv
// Shared types and constants for the sonic_scan ultrasonic ranging sequencer.
package sonic_pkg;

  // Sequencer states, one pass through TRIG..GAP per sensor slot
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_GAP       = 3'd4
  } scan_state_e;

  // Default timing at a 5 MHz clock: 10 us trigger, 38 ms timeout, 60 ms slot
  localparam int TRIG_CYCLES_5MHZ    = 50;
  localparam int TIMEOUT_CYCLES_5MHZ = 190000;
  localparam int SLOT_CYCLES_5MHZ    = 300000;

  // Widest supported result; the timeout code is sliced down to WIDTH
  localparam int                   MAX_WIDTH    = 32;
  localparam logic [MAX_WIDTH-1:0] TIMEOUT_CODE = {MAX_WIDTH{1'b1}};

  // One-hot decode of a sensor index (up to 16 sensors)
  function automatic logic [15:0] sensor_onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/sonic_sync.sv
// N-bit two-flop synchronizer for the asynchronous echo pins.
module sonic_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two register stages to settle metastability before the pins are used
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/sonic_scan.sv
// Round-robin HC-SR04 sequencer: triggers each sensor in its own fixed-length
// slot, times the echo pulse and emits one tagged result per slot.
module sonic_scan
  import sonic_pkg::*;
#(
  parameter int N_SENSORS      = 4,
  parameter int WIDTH          = 30,
  parameter int TRIG_CYCLES    = TRIG_CYCLES_5MHZ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_5MHZ,
  parameter int SLOT_CYCLES    = SLOT_CYCLES_5MHZ,
  localparam int ID_W          = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic                 data_valid,
  output logic [ID_W-1:0]      data_id,
  output logic [WIDTH-1:0]     data,
  output logic                 timeout
);

  if (N_SENSORS < 1 || N_SENSORS > 16) begin : g_bad_count
    $error("sonic_scan: N_SENSORS must be 1..16");
  end
  if (!(TRIG_CYCLES < TIMEOUT_CYCLES && TIMEOUT_CYCLES < SLOT_CYCLES - 4)) begin : g_bad_timing
    $error("sonic_scan: need TRIG_CYCLES < TIMEOUT_CYCLES < SLOT_CYCLES-4");
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH ||
      longint'(SLOT_CYCLES) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_width
    $error("sonic_scan: WIDTH too small for SLOT_CYCLES");
  end

  scan_state_e            state_r, state_nxt_s;
  logic [N_SENSORS-1:0]   echo_sync_s, echo_prev_r;
  logic [WIDTH-1:0]       slot_cnt_r, width_cnt_r;
  logic [ID_W-1:0]        sel_r, sel_nxt_s;
  logic                   echo_cur_s, echo_old_s, rise_s, fall_s;
  logic                   timeout_hit_s, slot_end_s, trig_done_s, result_load_s;
  logic [N_SENSORS-1:0]   trig_nxt_s, trig_r;
  logic                   data_valid_r, timeout_r;
  logic [ID_W-1:0]        data_id_r;
  logic [WIDTH-1:0]       data_r;

  sonic_sync #(.W(N_SENSORS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (echo),
    .q   (echo_sync_s)
  );

  // Only the selected sensor's echo matters; others are ignored outside their slot
  assign echo_cur_s    = echo_sync_s[sel_r];
  assign echo_old_s    = echo_prev_r[sel_r];
  assign rise_s        = echo_cur_s & ~echo_old_s;
  assign fall_s        = ~echo_cur_s & echo_old_s;
  assign trig_done_s   = (slot_cnt_r == WIDTH'(TRIG_CYCLES - 1));
  assign slot_end_s    = (slot_cnt_r == WIDTH'(SLOT_CYCLES - 1));
  assign timeout_hit_s = ((state_r == S_WAIT_RISE) || (state_r == S_MEASURE)) &&
                         (slot_cnt_r == WIDTH'(TIMEOUT_CYCLES));

  // Previous synchronized echo, kept for all bits so edges are seen from slot entry
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_prev_r <= {N_SENSORS{1'b0}};
    end else begin
      echo_prev_r <= echo_sync_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; timeout wins over a coincident falling edge
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (enable) state_nxt_s = S_TRIG;
        else        state_nxt_s = S_IDLE;
      end
      S_TRIG: begin
        if (trig_done_s) state_nxt_s = S_WAIT_RISE;
        else             state_nxt_s = S_TRIG;
      end
      S_WAIT_RISE: begin
        if (timeout_hit_s) state_nxt_s = S_GAP;
        else if (rise_s)   state_nxt_s = S_MEASURE;
        else               state_nxt_s = S_WAIT_RISE;
      end
      S_MEASURE: begin
        if (timeout_hit_s || fall_s) state_nxt_s = S_GAP;
        else                         state_nxt_s = S_MEASURE;
      end
      S_GAP: begin
        if (slot_end_s && enable) state_nxt_s = S_TRIG;
        else if (slot_end_s)      state_nxt_s = S_IDLE;
        else                      state_nxt_s = S_GAP;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode: next sensor index, next trigger pattern, result strobe
  always_comb begin
    sel_nxt_s     = sel_r;
    trig_nxt_s    = {N_SENSORS{1'b0}};
    result_load_s = timeout_hit_s || ((state_r == S_MEASURE) && fall_s);
    if (state_r == S_GAP && slot_end_s) begin
      if (sel_r == ID_W'(N_SENSORS - 1)) sel_nxt_s = {ID_W{1'b0}};
      else                               sel_nxt_s = sel_r + ID_W'(1);
    end else begin
      sel_nxt_s = sel_r;
    end
    if (state_nxt_s == S_TRIG) begin
      trig_nxt_s = N_SENSORS'(sensor_onehot(4'(sel_nxt_s)));
    end else begin
      trig_nxt_s = {N_SENSORS{1'b0}};
    end
  end

  // Slot timer (cleared on TRIG entry) and saturating echo width counter
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_r  <= {WIDTH{1'b0}};
      width_cnt_r <= {WIDTH{1'b0}};
      sel_r       <= {ID_W{1'b0}};
    end else begin
      sel_r <= sel_nxt_s;
      if (state_nxt_s == S_TRIG && state_r != S_TRIG) begin
        slot_cnt_r <= {WIDTH{1'b0}};
      end else if (state_r != S_IDLE) begin
        slot_cnt_r <= slot_cnt_r + WIDTH'(1);
      end else begin
        slot_cnt_r <= slot_cnt_r;
      end
      if (state_r == S_WAIT_RISE && rise_s) begin
        width_cnt_r <= WIDTH'(1);
      end else if (state_r == S_MEASURE && echo_cur_s &&
                   width_cnt_r != TIMEOUT_CODE[WIDTH-1:0]) begin
        width_cnt_r <= width_cnt_r + WIDTH'(1);
      end else begin
        width_cnt_r <= width_cnt_r;
      end
    end
  end

  // Registered outputs; result fields hold until the next strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_r       <= {N_SENSORS{1'b0}};
      data_valid_r <= 1'b0;
      data_id_r    <= {ID_W{1'b0}};
      data_r       <= {WIDTH{1'b0}};
      timeout_r    <= 1'b0;
    end else begin
      trig_r       <= trig_nxt_s;
      data_valid_r <= result_load_s;
      if (result_load_s) begin
        data_id_r <= sel_r;
        timeout_r <= timeout_hit_s;
        data_r    <= timeout_hit_s ? TIMEOUT_CODE[WIDTH-1:0] : width_cnt_r;
      end else begin
        data_id_r <= data_id_r;
        timeout_r <= timeout_r;
        data_r    <= data_r;
      end
    end
  end

  assign trig       = trig_r;
  assign data_valid = data_valid_r;
  assign data_id    = data_id_r;
  assign data       = data_r;
  assign timeout    = timeout_r;

endmodule
